// File: rtl/iq_mag_sq.sv
// Squared magnitude I^2+Q^2 of signed I/Q samples: 3-stage stall-able valid/ready pipeline.
// Define IQ_MAGSQ_PEAK_EN to add the running-peak tracker (peak_clr / peak_out).
module iq_mag_sq #(
    parameter int unsigned IQ_WIDTH   = 24,
    parameter int unsigned DATA_WIDTH = 2 * IQ_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IQ_WIDTH-1:0]   i_in,
    input  logic [IQ_WIDTH-1:0]   q_in,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef IQ_MAGSQ_PEAK_EN
    input  logic                  peak_clr,
    output logic [DATA_WIDTH-1:0] peak_out,
`endif
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned SqWidth = 2 * IQ_WIDTH - 1;

    logic                       adv;
    logic                       s0_valid_q, s1_valid_q, s2_valid_q;
    logic signed [IQ_WIDTH-1:0] s0_i_q, s0_q_q;
    logic signed [SqWidth-1:0]  i_ext, q_ext;
    logic [SqWidth-1:0]         ii_d, qq_d;
    logic [SqWidth-1:0]         s1_ii_q, s1_qq_q;
    logic [DATA_WIDTH-1:0]      sum_d;
    logic [DATA_WIDTH-1:0]      s2_sum_q;

    // Whole pipeline advances in lockstep; it only freezes when the output is held.
    assign adv       = !s2_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = s2_valid_q;
    assign data_out  = s2_sum_q;

    // Squares of a signed value fit in 2*IQ_WIDTH-1 unsigned bits, so the low bits are exact.
    always_comb begin
        i_ext = SqWidth'(s0_i_q);
        q_ext = SqWidth'(s0_q_q);
        ii_d  = $unsigned(i_ext * i_ext);
        qq_d  = $unsigned(q_ext * q_ext);
        sum_d = DATA_WIDTH'(s1_ii_q) + DATA_WIDTH'(s1_qq_q);
    end

    // Data registers only load behind a valid predecessor, so data_out holds across bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s0_i_q     <= '0;
            s0_q_q     <= '0;
            s1_ii_q    <= '0;
            s1_qq_q    <= '0;
            s2_sum_q   <= '0;
        end else if (adv) begin
            s0_valid_q <= in_valid;
            s1_valid_q <= s0_valid_q;
            s2_valid_q <= s1_valid_q;
            if (in_valid) begin
                s0_i_q <= i_in;
                s0_q_q <= q_in;
            end
            if (s0_valid_q) begin
                s1_ii_q <= ii_d;
                s1_qq_q <= qq_d;
            end
            if (s1_valid_q) begin
                s2_sum_q <= sum_d;
            end
        end
    end

`ifdef IQ_MAGSQ_PEAK_EN
    logic                  out_xfer;
    logic [DATA_WIDTH-1:0] peak_q;

    assign out_xfer = s2_valid_q & out_ready;
    assign peak_out = peak_q;

    // A clear coinciding with a transfer restarts the peak from that transfer's value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= out_xfer ? s2_sum_q : '0;
        end else if (out_xfer && (s2_sum_q > peak_q)) begin
            peak_q <= s2_sum_q;
        end
    end
`endif

endmodule

// File: tb/tb_iq_mag_sq.sv
// Directed bench for iq_mag_sq with a queue scoreboard of expected magnitudes.
// Build with IQ_MAGSQ_PEAK_EN defined to also exercise the peak tracker.
module tb_iq_mag_sq;

    localparam int unsigned IQW = 24;
    localparam int unsigned DW  = 48;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [IQW-1:0] i_in, q_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         data_out;
`ifdef IQ_MAGSQ_PEAK_EN
    logic                  peak_clr;
    logic [DW-1:0]         peak_out;
`endif

    int            checks = 0;
    int            errors = 0;
    int            out_cnt = 0;
    bit            in_xfer;
    bit            stalled = 1'b0;
    logic [DW-1:0] held;
    logic [DW-1:0] sb[$];

    iq_mag_sq #(.IQ_WIDTH(IQW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_in      (i_in),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef IQ_MAGSQ_PEAK_EN
        .peak_clr  (peak_clr),
        .peak_out  (peak_out),
`endif
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model(input int i, input int q);
        longint a = i;
        longint b = q;
        return DW'(a * a + b * b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples just before the coming rising edge, updates the scoreboard, then moves to the
    // next falling edge where new inputs are driven.
    task automatic cycle();
        logic [DW-1:0] exp;
        #1;
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (stalled) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(data_out), 64'(held));
        end
        in_xfer = in_valid && in_ready;
        if (in_xfer) sb.push_back(model(int'(i_in), int'(q_in)));
        if (out_valid && out_ready) begin
            out_cnt++;
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("sb_data", 64'(data_out), 64'(exp));
            end
        end
        stalled = out_valid && !out_ready;
        held    = data_out;
        @(negedge clk);
    endtask

    task automatic drive(input int i, input int q, input logic v);
        i_in     = IQW'(i);
        q_in     = IQW'(q);
        in_valid = v;
    endtask

    task automatic single(input int i, input int q, input logic [DW-1:0] exp, input string tag);
        drive(i, q, 1'b1);
        cycle();
        drive(0, 0, 1'b0);
        cycle();
        cycle();
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(data_out), 64'(exp));
        cycle();
        #1;
        chk({tag, "_one_cycle"}, 64'(out_valid), 64'd0);
        cycle();
    endtask

    initial begin
        int k;
        int budget;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 1'b0);
`ifdef IQ_MAGSQ_PEAK_EN
        peak_clr = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
`ifdef IQ_MAGSQ_PEAK_EN
        chk("rst_peak", 64'(peak_out), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single sample latency and boundary values
        single(3, 4, 48'd25, "t1");
        single(-8388608, -8388608, 48'h8000_0000_0000, "t2_min");
        single(8388607, 0, 48'h3FFF_FF00_0001, "t2_max");
        single(0, 0, 48'd0, "t2_zero");

        // Random backpressure stream
        out_cnt = 0;
        k = 1;
        budget = 0;
        while (k <= 20 && budget < 500) begin
            drive(k, -k, 1'b1);
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            if (in_xfer) k++;
            budget++;
        end
        drive(0, 0, 1'b0);
        budget = 0;
        while (sb.size() > 0 && budget < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            budget++;
        end
        out_ready = 1'b1;
        cycle();
        chk("t3_all_in", 64'(k), 64'd21);
        chk("t3_out_count", 64'(out_cnt), 64'd20);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Full throughput after a 3-cycle fill
        for (int j = 0; j < 10; j++) begin
            drive(100 * j + 1, -7 * j, 1'b1);
            #1;
            chk("t4_fill", 64'(out_valid), 64'(j >= 3));
            cycle();
        end
        drive(0, 0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("t4_drain", 64'(out_valid), 64'd1);
            cycle();
        end
        #1;
        chk("t4_empty", 64'(out_valid), 64'd0);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with samples in flight
        for (int j = 0; j < 3; j++) begin
            drive(5 + j, 6, 1'b1);
            cycle();
        end
        drive(0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_data", 64'(data_out), 64'd0);
        sb.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_cnt = 0;
        drive(1, 1, 1'b1);
        cycle();
        drive(0, 0, 1'b0);
        for (int j = 0; j < 8; j++) cycle();
        chk("t5_one_output", 64'(out_cnt), 64'd1);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

`ifdef IQ_MAGSQ_PEAK_EN
        single(3, 4, 48'd25, "t6_a");
        single(6, 8, 48'd100, "t6_b");
        single(3, 0, 48'd9, "t6_c");
        chk("t6_peak", 64'(peak_out), 64'd100);
        drive(0, 3, 1'b1);
        cycle();
        drive(0, 0, 1'b0);
        cycle();
        cycle();
        #1;
        chk("t6_clr_valid", 64'(out_valid), 64'd1);
        peak_clr = 1'b1;
        cycle();
        peak_clr = 1'b0;
        #1;
        chk("t6_peak_clr", 64'(peak_out), 64'd9);
        cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
